mem_copy_master: RTL and testbench



---
 rtl/mem_copy_master.sv | 194 +++++++++++++++++++
 tb/tb_mem_copy_master.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_master.sv
// -----------------------------------------------------------------------------
// mem_copy_master
//   Bus initiator that copies len_i 32-bit words from src_addr_i to dst_addr_i,
//   one read followed by one write per word, with a single transaction in
//   flight at a time on a req/rsp valid-ready bus.
//
//   Optional build macro: MEM_COPY_ABORT_EN adds abort_i / aborted_o.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start_i               launch pulse, accepted only in IDLE
//   src_addr_i/dst_addr_i byte addresses (bits [1:0] ignored), len_i words
//   busy_o, done_o        status: busy while copying, one-cycle done pulse
//   addr_o/data_o/sel_o/we_o/req_valid_o/req_ready_i   request channel
//   data_i/rsp_valid_i/rsp_ready_o                     response channel
//   abort_i, aborted_o    (MEM_COPY_ABORT_EN only) early stop and its status
// -----------------------------------------------------------------------------
module mem_copy_master #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [31:0]      dst_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      addr_o,
  output logic [31:0]      data_o,
  output logic [3:0]       sel_o,
  output logic             we_o,
  input  logic [31:0]      data_i,
  output logic             req_valid_o,
  input  logic             req_ready_i,
  input  logic             rsp_valid_i,
  output logic             rsp_ready_o
`ifdef MEM_COPY_ABORT_EN
  ,
  input  logic             abort_i,
  output logic             aborted_o
`endif
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_RSP, WR_REQ, WR_RSP, DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_q, src_d, dst_q, dst_d, data_q, data_d, addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d, done_q, done_d, we_q, we_d;
  logic             req_valid_q, req_valid_d, rsp_ready_q, rsp_ready_d;
`ifdef MEM_COPY_ABORT_EN
  logic             abort_pend_q, abort_pend_d, aborted_q, aborted_d;
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    data_d  = data_q;
`ifdef MEM_COPY_ABORT_EN
    abort_pend_d = abort_pend_q;
    aborted_d    = aborted_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d = {src_addr_i[31:2], 2'b00};
          dst_d = {dst_addr_i[31:2], 2'b00};
          rem_d = len_i;
          state_d = (len_i == '0) ? DONE : RD_REQ;
`ifdef MEM_COPY_ABORT_EN
          abort_pend_d = 1'b0;
          aborted_d    = 1'b0;
`endif
        end
      end
      RD_REQ, WR_REQ: begin
        if (req_ready_i) begin
          state_d = (state_q == RD_REQ) ? RD_RSP : WR_RSP;
`ifdef MEM_COPY_ABORT_EN
          // Request already accepted: its response must still be collected.
          if (abort_i) abort_pend_d = 1'b1;
`endif
        end
`ifdef MEM_COPY_ABORT_EN
        else if (abort_i) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end
`endif
      end
      RD_RSP: begin
`ifdef MEM_COPY_ABORT_EN
        if (abort_i) abort_pend_d = 1'b1;
`endif
        if (rsp_valid_i) begin
          data_d  = data_i;
          state_d = WR_REQ;
`ifdef MEM_COPY_ABORT_EN
          // Aborted read: the fetched word is never written.
          if (abort_i || abort_pend_q) begin
            state_d   = DONE;
            aborted_d = 1'b1;
          end
`endif
        end
      end
      WR_RSP: begin
`ifdef MEM_COPY_ABORT_EN
        if (abort_i) abort_pend_d = 1'b1;
`endif
        if (rsp_valid_i) begin
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          rem_d   = rem_q - LEN_W'(1);
          state_d = (rem_q == LEN_W'(1)) ? DONE : RD_REQ;
`ifdef MEM_COPY_ABORT_EN
          if (abort_i || abort_pend_q) begin
            state_d   = DONE;
            aborted_d = 1'b1;
          end
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so they line up with the
  // state they belong to; the address is rebuilt from the next src/dst.
  always_comb begin
    req_valid_d = (state_d == RD_REQ) || (state_d == WR_REQ);
    rsp_ready_d = (state_d == RD_RSP) || (state_d == WR_RSP);
    we_d        = (state_d == WR_REQ);
    busy_d      = (state_d != IDLE);
    // done trails the DONE state by one cycle, coinciding with busy falling.
    done_d      = (state_q == DONE);
    addr_d      = addr_q;
    if (state_d == RD_REQ)      addr_d = src_d;
    else if (state_d == WR_REQ) addr_d = dst_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      data_q      <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_valid_q <= 1'b0;
      rsp_ready_q <= 1'b0;
`ifdef MEM_COPY_ABORT_EN
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rem_q       <= rem_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      req_valid_q <= req_valid_d;
      rsp_ready_q <= rsp_ready_d;
`ifdef MEM_COPY_ABORT_EN
      abort_pend_q <= abort_pend_d;
      aborted_q    <= aborted_d;
`endif
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign addr_o      = addr_q;
  assign data_o      = data_q;
  assign sel_o       = 4'hF;
  assign we_o        = we_q;
  assign req_valid_o = req_valid_q;
  assign rsp_ready_o = rsp_ready_q;
`ifdef MEM_COPY_ABORT_EN
  assign aborted_o   = aborted_q;
`endif

endmodule

// File: tb/tb_mem_copy_master.sv
module tb_mem_copy_master;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic [31:0]      src_addr_i = '0, dst_addr_i = '0;
  logic [LEN_W-1:0] len_i = '0;
  logic             busy_o, done_o, we_o, req_valid_o, rsp_ready_o;
  logic [31:0]      addr_o, data_o;
  logic [3:0]       sel_o;
  logic [31:0]      data_i = '0;
  logic             req_ready_i = 1'b0, rsp_valid_i = 1'b0;
`ifdef MEM_COPY_ABORT_EN
  logic             abort_i = 1'b0;
  logic             aborted_o;
`endif

  always #5 clk = ~clk;

  mem_copy_master #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .addr_o(addr_o), .data_o(data_o),
    .sel_o(sel_o), .we_o(we_o), .data_i(data_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o)
`ifdef MEM_COPY_ABORT_EN
    , .abort_i(abort_i), .aborted_o(aborted_o)
`endif
  );

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: a word memory plus the list of bus transactions a copy
  // must produce, built from src/dst/len alone.
  typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} txn_t;
  txn_t expq[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_addrs[$];

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'hC0DE0000);
  endfunction

  int   stall_cfg = 0, rdelay_cfg = 0;
  bit   pend = 0, prev_stall = 0;
  txn_t cur, prev_req;
  int   rwait = 0, stall_cnt = 0;
  int   rd_cnt = 0, wr_cnt = 0, cyc = 0, first_rd = -1, done_cyc = -1;
  int   done_cnt = 0, busy_cyc = 0;

  // Responder + compare process: acts on the falling edge, so DUT outputs are
  // settled and the handshake decisions apply to the next rising edge.
  always @(negedge clk) begin
    cyc++;
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    if (!rst_n) begin
      pend = 0; prev_stall = 0; stall_cnt = 0;
    end else begin
      chk("sel", 32'(sel_o), 32'hF);
      chk("valid_ready_excl", 32'(req_valid_o & rsp_ready_o), 32'h0);
      if (busy_o) busy_cyc++;
      if (done_o) begin done_cnt++; done_cyc = cyc; end
      if (pend) begin
        chk("no_req_while_pending", 32'(req_valid_o), 32'h0);
        if (rwait > 0) rwait--;
        else begin
          rsp_valid_i = 1'b1;
          data_i = cur.we ? 32'h0 : rd_mem(cur.addr);
          if (rsp_ready_o) begin
            if (cur.we) mem[cur.addr] = cur.data;
            pend = 0;
          end
        end
      end else if (req_valid_o) begin
        if (prev_stall) begin
          chk("stall_addr", addr_o, prev_req.addr);
          chk("stall_we", 32'(we_o), 32'(prev_req.we));
          if (we_o) chk("stall_data", data_o, prev_req.data);
        end
        if (first_rd < 0 && !we_o) first_rd = cyc;
        if (stall_cnt < stall_cfg) begin
          stall_cnt++;
          prev_stall = 1;
          prev_req = '{we_o, addr_o, data_o};
        end else begin
          stall_cnt = 0; prev_stall = 0;
          req_ready_i = 1'b1;
          if (expq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: got we=%0d addr=%h expected no request", we_o, addr_o);
          end else begin
            txn_t e;
            e = expq.pop_front();
            chk("req_we", 32'(we_o), 32'(e.we));
            chk("req_addr", addr_o, e.addr);
            if (e.we) chk("req_data", data_o, e.data);
          end
          if (we_o) wr_cnt++;
          else begin rd_cnt++; rd_addrs.push_back(addr_o); end
          cur = '{we_o, addr_o, data_o};
          pend = 1;
          rwait = rdelay_cfg;
        end
      end
    end
  end

  task automatic prep(input logic [31:0] s, input logic [31:0] d, input int n,
                      input int st, input int rd);
    logic [31:0] sa, da;
    sa = {s[31:2], 2'b00};
    da = {d[31:2], 2'b00};
    stall_cfg = st; rdelay_cfg = rd;
    expq.delete(); rd_addrs.delete();
    for (int i = 0; i < n; i++) begin
      expq.push_back('{1'b0, sa + 32'(4*i), 32'h0});
      expq.push_back('{1'b1, da + 32'(4*i), rd_mem(sa + 32'(4*i))});
    end
    rd_cnt = 0; wr_cnt = 0; first_rd = -1; done_cyc = -1; done_cnt = 0; busy_cyc = 0;
  endtask

  task automatic kick(input logic [31:0] s, input logic [31:0] d, input int n);
    @(negedge clk);
    src_addr_i = s; dst_addr_i = d; len_i = LEN_W'(n); start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input bit mid_start);
    for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
      @(negedge clk);
      if (mid_start && k == 6) begin
        start_i = 1'b1; src_addr_i = 32'hDEAD0000; dst_addr_i = 32'hBEEF0000; len_i = LEN_W'(9);
      end else start_i = 1'b0;
    end
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("busy_low_after", 32'(busy_o), 32'h0);
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int st, input int rd, input bit mid_start);
    prep(s, d, n, st, rd);
    kick(s, d, n);
    wait_done(mid_start);
    chk("all_txns_seen", 32'(expq.size()), 32'h0);
    chk("read_count", 32'(rd_cnt), 32'(n));
    chk("write_count", 32'(wr_cnt), 32'(n));
    for (int i = 0; i < n; i++)
      chk("dst_word", rd_mem({d[31:2], 2'b00} + 32'(4*i)), rd_mem({s[31:2], 2'b00} + 32'(4*i)));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_req_valid", 32'(req_valid_o), 32'h0);
    chk("rst_rsp_ready", 32'(rsp_ready_o), 32'h0);
    chk("rst_addr", addr_o, 32'h0);
    chk("rst_data", data_o, 32'h0);
    rst_n = 1'b1;

    // Basic copy, zero-wait responder.
    mem[32'h1000] = 32'hA; mem[32'h1004] = 32'hB; mem[32'h1008] = 32'hC;
    run_copy(32'h1000, 32'h2000, 3, 0, 0, 1'b0);
    chk("basic_w0", mem[32'h2000], 32'hA);
    chk("basic_w1", mem[32'h2004], 32'hB);
    chk("basic_w2", mem[32'h2008], 32'hC);
    chk("basic_latency", 32'(done_cyc - first_rd), 32'd13);

    // Backpressure on requests and delayed responses.
    run_copy(32'h3000, 32'h3800, 4, 3, 2, 1'b0);

    // Zero-length copy.
    run_copy(32'h4000, 32'h4800, 0, 0, 0, 1'b0);
    chk("len0_busy_cycles", 32'(busy_cyc), 32'd1);

    // Source address wrap.
    run_copy(32'hFFFFFFF8, 32'h5000, 3, 0, 0, 1'b0);
    chk("wrap_rd0", rd_addrs[0], 32'hFFFFFFF8);
    chk("wrap_rd1", rd_addrs[1], 32'hFFFFFFFC);
    chk("wrap_rd2", rd_addrs[2], 32'h00000000);

    // Unaligned source plus a start pulse in the middle of the copy.
    run_copy(32'h1003, 32'h6000, 4, 1, 1, 1'b1);
    chk("unaligned_rd0", rd_addrs[0], 32'h1000);

    // Asynchronous reset while a write request is pending.
    prep(32'h7000, 32'h7800, 4, 2, 0);
    kick(32'h7000, 32'h7800, 4);
    begin
      bit found;
      found = 0;
      for (int k = 0; k < 200 && !found; k++) begin
        @(negedge clk);
        if (req_valid_o && we_o) found = 1;
      end
      chk("reached_wr_req", 32'(found), 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_o), 32'h0);
    chk("arst_done", 32'(done_o), 32'h0);
    chk("arst_req_valid", 32'(req_valid_o), 32'h0);
    chk("arst_rsp_ready", 32'(rsp_ready_o), 32'h0);
    chk("arst_we", 32'(we_o), 32'h0);
    chk("arst_addr", addr_o, 32'h0);
    chk("arst_data", data_o, 32'h0);
    chk("arst_sel", 32'(sel_o), 32'hF);
    done_cnt = 0;
    repeat (2) @(negedge clk);
    chk("arst_no_done", 32'(done_cnt), 32'h0);
    rst_n = 1'b1;
    run_copy(32'h7000, 32'h8800, 4, 0, 0, 1'b0);

`ifdef MEM_COPY_ABORT_EN
    // Abort while the second read's response is outstanding.
    prep(32'h9000, 32'h9800, 5, 0, 2);
    while (expq.size() > 3) void'(expq.pop_back());
    kick(32'h9000, 32'h9800, 5);
    begin
      bit hit;
      hit = 0;
      for (int k = 0; k < 200 && !hit; k++) begin
        @(negedge clk);
        if (rsp_ready_o && rd_cnt == 2) begin hit = 1; abort_i = 1'b1; end
      end
      @(negedge clk);
      abort_i = 1'b0;
      chk("abort_point_reached", 32'(hit), 32'd1);
    end
    wait_done(1'b0);
    chk("abort_txns", 32'(expq.size()), 32'h0);
    chk("abort_reads", 32'(rd_cnt), 32'd2);
    chk("abort_writes", 32'(wr_cnt), 32'd1);
    chk("abort_no_w1", 32'(mem.exists(32'h9804)), 32'h0);
    chk("aborted_flag", 32'(aborted_o), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
